// File: rtl/roberto_pkg.sv
// rtl/roberto_pkg.sv - shared state encodings and frame limits for roberto_uc
package roberto_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MEDE        = 4'h2,
    ESPERA_SEG  = 4'h3,
    TRANSMITE   = 4'h4,
    ESPERA_TX   = 4'h5,
    PROX_CHAR   = 4'h6,
    PROX_SENSOR = 4'h7,
    FIM_CICLO   = 4'h8
  } estado_t;

  typedef enum logic {
    RX_LIMPA = 1'b0,
    RX_ATIVO = 1'b1
  } estado_rx_t;

  localparam logic [1:0] ULTIMO_CHAR    = 2'd3;
  localparam logic [1:0] ULTIMO_SENSOR  = 2'd2;
  localparam logic [1:0] ULTIMO_SLOT_RX = 2'd3;

endpackage

// File: rtl/roberto_uc_rx.sv
// rtl/roberto_uc_rx.sv - reception sequencer: slot stepping and frame-complete pulse
module roberto_uc_rx
  import roberto_pkg::*;
(
  input  logic       clock,
  input  logic       rst_n,
  input  logic       pronto_recepcao,
  input  logic [1:0] Q_recepcao,
  output logic       cont_recepcao,
  output logic       quadro_recebido,
  output logic       zera_recpcao
);

  estado_rx_t estado_q, estado_d;
  logic       quadro_q, quadro_d;
  logic       zera_q, zera_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= RX_LIMPA;
      quadro_q <= 1'b0;
      zera_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      quadro_q <= quadro_d;
      zera_q   <= zera_d;
    end
  end

  // The clear is registered so it can never glitch while the reset synchronizer releases.
  always_comb begin
    estado_d = RX_ATIVO;
    zera_d   = (estado_q == RX_LIMPA);
    quadro_d = (estado_q == RX_ATIVO) && pronto_recepcao && (Q_recepcao == ULTIMO_SLOT_RX);
  end

  assign cont_recepcao   = (estado_q == RX_ATIVO) && pronto_recepcao;
  assign quadro_recebido = quadro_q;
  assign zera_recpcao    = zera_q;

endmodule

// File: rtl/roberto_uc.sv
// rtl/roberto_uc.sv - roberto_fd control unit; ROBERTO_RX_EN compiles in the reception sequencer
module roberto_uc
  import roberto_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_seg,
  input  logic       pronto_serial,
  input  logic       pronto_recepcao,
  input  logic [1:0] Q_2,
  input  logic [1:0] Q_3,
  input  logic [1:0] Q_recepcao,
  output logic       zera_sensor,
  output logic       zera_serial,
  output logic       zera_seg,
  output logic       zera_2,
  output logic       zera_3,
  output logic       zera_recpcao,
  output logic       cont_seg,
  output logic       cont_2,
  output logic       cont_3,
  output logic       cont_recepcao,
  output logic       medir,
  output logic       partida_tx,
  output logic       quadro_recebido,
  output logic [3:0] db_estado
);

  logic [1:0] sinc_q;
  logic       rst_n;
  estado_t    estado_q, estado_d;

  // Asserts immediately, releases two clocks after reset goes high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sinc_q <= 2'b00;
    else        sinc_q <= {sinc_q[0], 1'b1};
  end
  assign rst_n = sinc_q[1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) estado_q <= INICIAL;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:     if (ligar) estado_d = PREPARA;
      PREPARA:     estado_d = MEDE;
      MEDE:        estado_d = ESPERA_SEG;
      ESPERA_SEG:  if (pronto_seg) estado_d = TRANSMITE;
      TRANSMITE:   estado_d = ESPERA_TX;
      ESPERA_TX: begin
        if (pronto_serial) begin
          if (Q_3 != ULTIMO_CHAR)        estado_d = PROX_CHAR;
          else if (Q_2 != ULTIMO_SENSOR) estado_d = PROX_SENSOR;
          else                           estado_d = FIM_CICLO;
        end
      end
      PROX_CHAR:   estado_d = TRANSMITE;
      PROX_SENSOR: estado_d = TRANSMITE;
      FIM_CICLO:   estado_d = ligar ? MEDE : INICIAL;
      default:     estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zera_sensor = 1'b0;
    zera_serial = 1'b0;
    zera_seg    = 1'b0;
    zera_2      = 1'b0;
    zera_3      = 1'b0;
    cont_seg    = 1'b0;
    cont_2      = 1'b0;
    cont_3      = 1'b0;
    medir       = 1'b0;
    partida_tx  = 1'b0;
    case (estado_q)
      PREPARA: begin
        zera_sensor = 1'b1;
        zera_serial = 1'b1;
        zera_seg    = 1'b1;
        zera_2      = 1'b1;
        zera_3      = 1'b1;
      end
      MEDE: begin
        medir    = 1'b1;
        zera_seg = 1'b1;
      end
      ESPERA_SEG:  cont_seg   = 1'b1;
      TRANSMITE:   partida_tx = 1'b1;
      PROX_CHAR:   cont_3     = 1'b1;
      PROX_SENSOR: begin
        cont_2 = 1'b1;
        zera_3 = 1'b1;
      end
      FIM_CICLO: begin
        zera_2 = 1'b1;
        zera_3 = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

`ifdef ROBERTO_RX_EN
  roberto_uc_rx u_rx (
    .clock           (clock),
    .rst_n           (rst_n),
    .pronto_recepcao (pronto_recepcao),
    .Q_recepcao      (Q_recepcao),
    .cont_recepcao   (cont_recepcao),
    .quadro_recebido (quadro_recebido),
    .zera_recpcao    (zera_recpcao)
  );
`else
  // Receive path held cleared; its inputs are intentionally ignored.
  logic unused_rx;
  assign unused_rx       = ^{pronto_recepcao, Q_recepcao};
  assign cont_recepcao   = 1'b0;
  assign quadro_recebido = 1'b0;
  assign zera_recpcao    = 1'b1;
`endif

endmodule

// File: tb/tb_roberto_uc.sv
// tb/tb_roberto_uc.sv - randomized self-checking bench for roberto_uc with a datapath stub
module tb_roberto_uc;

`ifdef ROBERTO_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic clock = 1'b0;
  always #10 clock = ~clock;

  logic       reset, ligar, pronto_seg, pronto_serial, pronto_recepcao;
  logic [1:0] Q_2, Q_3, Q_recepcao;
  logic       zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_recpcao;
  logic       cont_seg, cont_2, cont_3, cont_recepcao, medir, partida_tx, quadro_recebido;
  logic [3:0] db_estado;

  roberto_uc dut (
    .clock(clock), .reset(reset), .ligar(ligar), .pronto_seg(pronto_seg),
    .pronto_serial(pronto_serial), .pronto_recepcao(pronto_recepcao),
    .Q_2(Q_2), .Q_3(Q_3), .Q_recepcao(Q_recepcao),
    .zera_sensor(zera_sensor), .zera_serial(zera_serial), .zera_seg(zera_seg),
    .zera_2(zera_2), .zera_3(zera_3), .zera_recpcao(zera_recpcao),
    .cont_seg(cont_seg), .cont_2(cont_2), .cont_3(cont_3), .cont_recepcao(cont_recepcao),
    .medir(medir), .partida_tx(partida_tx), .quadro_recebido(quadro_recebido),
    .db_estado(db_estado)
  );

  int checks = 0;
  int errors = 0;

  task automatic verifica(input string tag, input int obs, input int esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  // Stub and monitor state
  int         seg_cnt = 0, seg_alvo = 10, tx_timer = 0, cyc = 0;
  bit         rx_on = 0, quadro_due = 0, seg_ant = 0, medir_ant = 0, partida_ant = 0;
  logic [3:0] est_ant = 4'h0;
  logic [3:0] tx_obs[$];
  int         medir_cyc = -1, seg_cyc = -1, fim_next = -1;
  int         lat_err = 0, width_err = 0, hold_err = 0, prep_err = 0, prep_seen = 0;
  int         rx_tot = 0, rx_idx = 0, term_exp = 0, cont_rx_cnt = 0, quadro_cnt = 0, rx_err = 0;
  int         zrx_cnt = 0, zrx_low = 0;

  task automatic ciclo();
    logic [1:0] n2, n3, nr;
    int nseg;
    @(negedge clock);
    pronto_seg = (seg_cnt >= seg_alvo);
    if (tx_timer > 0) begin
      tx_timer--;
      pronto_serial = (tx_timer == 0);
    end else begin
      // spurious completion while still waiting for the measurement window
      pronto_serial = (est_ant == 4'h3) && !seg_ant && ($urandom_range(0, 7) == 0);
    end
    pronto_recepcao = rx_on && ($urandom_range(0, 3) == 0);
    #1;
    if (medir && medir_ant) width_err++;
    if (partida_tx && partida_ant) width_err++;
    if (db_estado == 4'h3 && !cont_seg) hold_err++;
    if (db_estado == 4'h1) begin
      prep_seen++;
      if (!(zera_sensor && zera_serial && zera_seg && zera_2 && zera_3) || medir || partida_tx) prep_err++;
    end
    if (medir && medir_cyc < 0) medir_cyc = cyc;
    if (db_estado == 4'h3 && pronto_seg) seg_cyc = cyc;
    if (partida_tx) begin
      tx_obs.push_back({Q_2, Q_3});
      tx_timer = $urandom_range(1, 8);
      if (seg_cyc >= 0) begin
        if (cyc - seg_cyc != 1) lat_err++;
        seg_cyc = -1;
      end
    end
    if (est_ant == 4'h8 && fim_next < 0) fim_next = db_estado;
    if (quadro_recebido !== quadro_due) rx_err++;
    if (cont_recepcao !== (RX_EN && pronto_recepcao)) rx_err++;
    quadro_due = RX_EN && pronto_recepcao && (rx_idx == 3);
    if (pronto_recepcao) begin
      rx_tot++;
      if (rx_idx == 3) term_exp++;
      rx_idx = (rx_idx + 1) % 4;
    end
    if (cont_recepcao) cont_rx_cnt++;
    if (quadro_recebido) quadro_cnt++;
    if (zera_recpcao) zrx_cnt++; else zrx_low++;
    nseg = zera_seg ? 0 : (cont_seg ? seg_cnt + 1 : seg_cnt);
    n2 = zera_2 ? 2'd0 : (cont_2 ? Q_2 + 2'd1 : Q_2);
    n3 = zera_3 ? 2'd0 : (cont_3 ? Q_3 + 2'd1 : Q_3);
    nr = zera_recpcao ? 2'd0 : (cont_recepcao ? Q_recepcao + 2'd1 : Q_recepcao);
    medir_ant = medir; partida_ant = partida_tx; est_ant = db_estado; seg_ant = pronto_seg;
    @(posedge clock);
    #1;
    seg_cnt = nseg; Q_2 = n2; Q_3 = n3; Q_recepcao = nr;
    cyc++;
  endtask

  // One full measurement + 12-character frame; drop_at >= 0 drops ligar after that many chars.
  task automatic quadro(input string tag, input int drop_at, output int fim_state);
    int guard = 0;
    tx_obs.delete();
    fim_next = -1;
    seg_alvo = $urandom_range(3, 20);
    while (fim_next < 0 && guard < 3000) begin
      if (drop_at >= 0 && tx_obs.size() >= drop_at) ligar = 1'b0;
      ciclo();
      guard++;
    end
    verifica({tag, "_timeout"}, int'(guard < 3000), 1);
    verifica({tag, "_chars"}, tx_obs.size(), 12);
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 4; c++)
        if (s * 4 + c < tx_obs.size())
          verifica($sformatf("%s_sensor%0d_char%0d", tag, s, c), tx_obs[s * 4 + c], (s << 2) | c);
    fim_state = fim_next;
  endtask

  task automatic chk_reset(input string tag);
    verifica({tag, "_db_estado"}, db_estado, 0);
    verifica({tag, "_medir"}, medir, 0);
    verifica({tag, "_partida_tx"}, partida_tx, 0);
    verifica({tag, "_zeras"}, {zera_sensor, zera_serial, zera_seg, zera_2, zera_3}, 0);
    verifica({tag, "_conts"}, {cont_seg, cont_2, cont_3, cont_recepcao}, 0);
    verifica({tag, "_quadro"}, quadro_recebido, 0);
    verifica({tag, "_zera_rx"}, zera_recpcao, RX_EN ? 0 : 1);
  endtask

  initial begin
    int fim, ligar_cyc, guard;
    reset = 1'b0; ligar = 1'b0; pronto_seg = 1'b0; pronto_serial = 1'b0; pronto_recepcao = 1'b0;
    Q_2 = 2'd0; Q_3 = 2'd0; Q_recepcao = 2'd0;
    repeat (3) @(negedge clock);
    #1;
    chk_reset("rst");

    // release: receive clear pulses once, main FSM idles
    @(posedge clock); #1;
    reset = 1'b1;
    zrx_cnt = 0; zrx_low = 0;
    repeat (6) ciclo();
    if (RX_EN) verifica("rel_zera_rx_pulses", zrx_cnt, 1);
    else       verifica("rel_zera_rx_low", zrx_low, 0);
    verifica("idle_db_estado", db_estado, 0);

    rx_on = 1'b1;
    ligar = 1'b1;
    ligar_cyc = cyc;
    medir_cyc = -1;
    prep_seen = 0;
    quadro("f1", -1, fim);
    verifica("f1_ligar_to_medir", medir_cyc - ligar_cyc, 2);
    verifica("f1_prepara_cycles", prep_seen, 1);
    verifica("f1_after_fim", fim, 2);

    quadro("f2", $urandom_range(1, 11), fim);
    verifica("f2_after_fim", fim, 0);
    repeat (5) ciclo();
    verifica("f2_idle_db_estado", db_estado, 0);

    // reset while waiting on the transmitter
    ligar = 1'b1;
    guard = 0;
    while (db_estado != 4'h5 && guard < 500) begin
      ciclo();
      guard++;
    end
    verifica("esp_tx_reached", db_estado, 5);
    #3;
    reset = 1'b0;
    rx_on = 1'b0; tx_timer = 0; quadro_due = 1'b0; rx_idx = 0;
    #1;
    chk_reset("rst_tx");
    repeat (2) ciclo();
    reset = 1'b1;
    zrx_cnt = 0; zrx_low = 0; prep_seen = 0; prep_err = 0;
    quadro("f3", 1, fim);
    verifica("f3_after_fim", fim, 0);
    verifica("f3_prepara_cycles", prep_seen, 1);
    if (RX_EN) verifica("f3_zera_rx_pulses", zrx_cnt, 1);
    else       verifica("f3_zera_rx_low", zrx_low, 0);

    rx_on = 1'b1;
    repeat (60) ciclo();

    verifica("medir_partida_width", width_err, 0);
    verifica("cont_seg_hold", hold_err, 0);
    verifica("seg_to_partida", lat_err, 0);
    verifica("prepara_outputs", prep_err, 0);
    verifica("rx_timing", rx_err, 0);
    verifica("rx_cont_total", cont_rx_cnt, RX_EN ? rx_tot : 0);
    verifica("rx_quadro_total", quadro_cnt, RX_EN ? term_exp : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
